// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: grants one completing requester per cycle and broadcasts its
// {tag, data} on a registered CDB. Define CDB_FIXED_PRIO_EN for fixed (lowest index) priority.
module cdb_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TAG_W   = 8,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic                      hold,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      cdb_valid,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [DATA_W-1:0]         cdb_data,
  output logic [CNT_W-1:0]          cdb_count
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic            grant_any;
  logic [IdxW-1:0] grant_idx;
  logic            grant_valid;
  logic [TAG_W-1:0]  sel_tag;
  logic [DATA_W-1:0] sel_data;

`ifdef CDB_FIXED_PRIO_EN
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!grant_any && req[k]) begin
        grant_any = 1'b1;
        grant_idx = IdxW'(k);
      end
    end
  end
`else
  logic [IdxW-1:0] ptr_q, ptr_d;
  int unsigned     rr_idx;

  // Search starts at ptr_q and wraps modulo NUM_REQ.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    rr_idx    = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      rr_idx = (32'(ptr_q) + k) % NUM_REQ;
      if (!grant_any && req[rr_idx[IdxW-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = rr_idx[IdxW-1:0];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant_valid) begin
      ptr_d = (grant_idx == IdxW'(NUM_REQ - 1)) ? '0 : grant_idx + IdxW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  // Grant is suppressed combinationally while reset is asserted.
  assign grant_valid = grant_any & ~hold & ~rst;

  always_comb begin
    gnt = '0;
    if (grant_valid) begin
      gnt[grant_idx] = 1'b1;
    end
  end

  assign sel_tag  = req_tag[32'(grant_idx) * TAG_W +: TAG_W];
  assign sel_data = req_data[32'(grant_idx) * DATA_W +: DATA_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
      cdb_count <= '0;
    end else begin
      cdb_valid <= grant_valid;
      if (grant_valid) begin
        cdb_tag  <= sel_tag;
        cdb_data <= sel_data;
        if (cdb_count != '1) begin
          cdb_count <= cdb_count + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus randomized traffic against a
// behavioural model of the grant rule, CDB register and saturating broadcast counter.
module tb_cdb_arbiter;

  localparam int N  = 4;
  localparam int TW = 8;
  localparam int DW = 32;
  localparam int CW = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*TW-1:0] req_tag = '0;
  logic [N*DW-1:0] req_data = '0;
  logic            hold = 1'b0;
  logic [N-1:0]    gnt;
  logic            cdb_valid;
  logic [TW-1:0]   cdb_tag;
  logic [DW-1:0]   cdb_data;
  logic [CW-1:0]   cdb_count;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int            m_ptr = 0;
  logic          m_valid = 1'b0;
  logic [TW-1:0] m_tag = '0;
  logic [DW-1:0] m_data = '0;
  logic [CW-1:0] m_cnt = '0;

  cdb_arbiter #(.NUM_REQ(N), .TAG_W(TW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_tag  (req_tag),
    .req_data (req_data),
    .hold     (hold),
    .gnt      (gnt),
    .cdb_valid(cdb_valid),
    .cdb_tag  (cdb_tag),
    .cdb_data (cdb_data),
    .cdb_count(cdb_count)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] exp_gnt(input logic [N-1:0] r, input logic h, input int p);
    int i;
    exp_gnt = '0;
    if (h || r == '0) return exp_gnt;
    for (int k = 0; k < N; k++) begin
`ifdef CDB_FIXED_PRIO_EN
      i = k;
`else
      i = (p + k) % N;
`endif
      if (r[i]) begin
        exp_gnt[i] = 1'b1;
        return exp_gnt;
      end
    end
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_valid = 1'b0; m_tag = '0; m_data = '0; m_cnt = '0;
  endtask

  task automatic model_clock(input logic [N-1:0] g);
    m_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (g[i]) begin
        m_valid = 1'b1;
        m_tag   = req_tag[i*TW +: TW];
        m_data  = req_data[i*DW +: DW];
        m_ptr   = (i + 1) % N;
        if (m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1'b1;
      end
    end
  endtask

  // Advance one clock edge, updating the model with the grant it expects; returns at edge+1.
  task automatic tick();
    logic [N-1:0] eg;
    eg = exp_gnt(req, hold, m_ptr);
    @(posedge clk);
    model_clock(eg);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    req = '0; hold = 1'b0; rst = 1'b1;
    #3 rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
  endtask

  task automatic set_src(input int i, input logic [TW-1:0] t, input logic [DW-1:0] d);
    req_tag[i*TW +: TW]  = t;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    req = '1; hold = 1'b0; rst = 1'b1;
    #1;
    checks++; if (gnt !== '0) begin errors++; $display("FAIL reset_gnt: got %b want 0", gnt); end
    checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", cdb_valid); end
    checks++; if (cdb_tag !== '0) begin errors++; $display("FAIL reset_tag: got %h want 0", cdb_tag); end
    checks++; if (cdb_data !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", cdb_data); end
    checks++; if (cdb_count !== '0) begin errors++; $display("FAIL reset_count: got %h want 0", cdb_count); end
    req = '0;
    #2 rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    do_reset();
    set_src(0, 8'h20, 32'd7);
    req = 4'b0001;
    #1;
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt: got %b want 0001", gnt); end
    tick();
    req = '0;
    checks++; if (cdb_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", cdb_valid); end
    checks++; if (cdb_tag !== 8'h20) begin errors++; $display("FAIL single_tag: got %h want 20", cdb_tag); end
    checks++; if (cdb_data !== 32'd7) begin errors++; $display("FAIL single_data: got %0d want 7", cdb_data); end
    checks++; if (cdb_count !== 16'd1) begin errors++; $display("FAIL single_count: got %0d want 1", cdb_count); end
  endtask

  task automatic test_round_robin();
    logic [N-1:0]  want;
    logic [TW-1:0] want_tag;
    do_reset();
    set_src(0, 8'h20, 32'h100);
    set_src(1, 8'h40, 32'h200);
    set_src(2, 8'h80, 32'h300);
    req = 4'b0111;
    for (int k = 0; k < 3; k++) begin
`ifdef CDB_FIXED_PRIO_EN
      want = 4'b0001; want_tag = 8'h20;
`else
      want = 4'b0001 << k; want_tag = 8'h20 << k;
`endif
      #1;
      checks++; if (gnt !== want) begin errors++; $display("FAIL rr_gnt[%0d]: got %b want %b", k, gnt, want); end
      tick();
`ifndef CDB_FIXED_PRIO_EN
      req[k] = 1'b0;
`endif
      checks++;
      if (cdb_valid !== 1'b1 || cdb_tag !== want_tag) begin
        errors++; $display("FAIL rr_cdb[%0d]: got v=%b tag=%h want v=1 tag=%h", k, cdb_valid, cdb_tag, want_tag);
      end
    end
    req = '0;
  endtask

  task automatic test_wrap();
`ifdef CDB_FIXED_PRIO_EN
    localparam logic [N-1:0] WrapFirst = 4'b0001;
`else
    localparam logic [N-1:0] WrapFirst = 4'b1000;
`endif
    do_reset();
    set_src(0, 8'h11, 32'hA0);
    set_src(2, 8'h33, 32'hA2);
    set_src(3, 8'h44, 32'hA3);
    req = 4'b0100;
    #1;
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL wrap_pre_gnt: got %b want 0100", gnt); end
    tick();
    req = 4'b1001;
    #1;
    checks++; if (gnt !== WrapFirst) begin errors++; $display("FAIL wrap_first_gnt: got %b want %b", gnt, WrapFirst); end
    tick();
    req = req & ~WrapFirst;
    checks++; if (cdb_tag !== m_tag) begin errors++; $display("FAIL wrap_first_tag: got %h want %h", cdb_tag, m_tag); end
    #1;
    checks++;
    if (gnt !== exp_gnt(req, hold, m_ptr)) begin
      errors++; $display("FAIL wrap_second_gnt: got %b want %b", gnt, exp_gnt(req, hold, m_ptr));
    end
    tick();
    req = '0;
    checks++; if (cdb_tag !== m_tag) begin errors++; $display("FAIL wrap_second_tag: got %h want %h", cdb_tag, m_tag); end
  endtask

  task automatic test_hold();
    do_reset();
    set_src(1, 8'h5A, 32'hDEAD);
    req = 4'b0010; hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (gnt !== '0) begin errors++; $display("FAIL hold_gnt[%0d]: got %b want 0", k, gnt); end
      tick();
      checks++; if (cdb_valid !== 1'b0) begin errors++; $display("FAIL hold_valid[%0d]: got %b want 0", k, cdb_valid); end
    end
    hold = 1'b0;
    #1;
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL hold_release_gnt: got %b want 0010", gnt); end
    tick();
    req = '0;
    checks++;
    if (cdb_valid !== 1'b1 || cdb_data !== 32'hDEAD) begin
      errors++; $display("FAIL hold_release_cdb: got v=%b d=%h want v=1 d=dead", cdb_valid, cdb_data);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < N; i++) set_src(i, 8'(8'h70 + i), 32'(1000 + i));
    req = 4'b1111; hold = 1'b0;
    tick();
    checks++; if (cdb_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre_valid: got %b want 1", cdb_valid); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({cdb_valid, cdb_tag, cdb_data, cdb_count, gnt} !== '0) begin
      errors++; $display("FAIL rstmid_clear: got v=%b t=%h d=%h c=%h g=%b want all 0",
                         cdb_valid, cdb_tag, cdb_data, cdb_count, gnt);
    end
    model_reset();
    #2 rst = 1'b0;
    #1;
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL rstmid_first_gnt: got %b want 0001", gnt); end
    req = '0;
    tick();
  endtask

  task automatic test_random();
    logic [N-1:0] eg;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      req  = N'($urandom_range(0, (1 << N) - 1));
      hold = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < N; i++) set_src(i, TW'($urandom), DW'($urandom));
      #1;
      eg = exp_gnt(req, hold, m_ptr);
      checks++; if (gnt !== eg) begin errors++; $display("FAIL rand_gnt[%0d]: got %b want %b", c, gnt, eg); end
      tick();
      checks++;
      if (cdb_valid !== m_valid || cdb_tag !== m_tag || cdb_data !== m_data || cdb_count !== m_cnt) begin
        errors++;
        $display("FAIL rand_cdb[%0d]: got v=%b t=%h d=%h c=%0d want v=%b t=%h d=%h c=%0d", c,
                 cdb_valid, cdb_tag, cdb_data, cdb_count, m_valid, m_tag, m_data, m_cnt);
      end
    end
    req = '0; hold = 1'b0;
  endtask

  task automatic test_saturation();
    set_src(0, 8'hEE, 32'h1234);
    req = 4'b0001; hold = 1'b0;
    for (int c = 0; c < 70000 && m_cnt != 16'hFFFE; c++) tick();
    checks++; if (cdb_count !== 16'hFFFE) begin errors++; $display("FAIL sat_pre: got %h want fffe", cdb_count); end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (cdb_count !== m_cnt) begin errors++; $display("FAIL sat_step[%0d]: got %h want %h", k, cdb_count, m_cnt); end
    end
    checks++; if (cdb_count !== 16'hFFFF) begin errors++; $display("FAIL sat_final: got %h want ffff", cdb_count); end
    req = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_hold();
    test_reset_mid();
    test_random();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
